// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbiter and cycle sequencer for the shared 7-bit address / 8-bit data
//   peripheral bus. Two requesters share the bus:
//     - the SPI slave controller, whose active-low read/write strobes are
//       asynchronous and are synchronised here (2 flops + previous-value flop),
//     - a local requester on clk using a level request / one-cycle ack handshake.
//   SPI has fixed priority, but a transaction in flight always completes.
//   Every transaction runs SETUP (1 cycle), ACCESS (WAIT_CYCLES cycles) and
//   HOLD (1 cycle), then returns to IDLE for one decision cycle.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   spi_addr/spi_wdata         SPI address / write data, stable while a strobe is low
//   spi_read_n/spi_write_n     asynchronous active-low SPI strobes
//   spi_rdata                  last SPI read result
//   loc_req/loc_we/loc_addr/loc_wdata   local request and its payload, sampled at grant
//   loc_rdata/loc_ack          last local read result / completion pulse (HOLD cycle)
//   mem_addr/mem_data          bus address / bidirectional bus data (driven on writes only)
//   mem_ce_n/mem_oe_n/mem_we_n active-low bus strobes
//   busy                       high whenever a transaction is in progress
module mem_bus_arbiter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] spi_addr,
   input  logic [7:0] spi_wdata,
   input  logic       spi_read_n,
   input  logic       spi_write_n,
   output logic [7:0] spi_rdata,
   input  logic       loc_req,
   input  logic       loc_we,
   input  logic [6:0] loc_addr,
   input  logic [7:0] loc_wdata,
   output logic [7:0] loc_rdata,
   output logic       loc_ack,
   output logic [6:0] mem_addr,
   inout  wire  [7:0] mem_data,
   output logic       mem_ce_n,
   output logic       mem_oe_n,
   output logic       mem_we_n,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t     state_r;
   logic [3:0] cnt_r;
   logic       rd_sync1_r, rd_sync2_r, rd_prev_r;
   logic       wr_sync1_r, wr_sync2_r, wr_prev_r;
   logic       spi_pend_r;
   logic       spi_dir_r;      // 0 = read, 1 = write
   logic       cur_we_r;       // direction of the granted transaction
   logic       cur_spi_r;      // 1 = SPI owns the current transaction
   logic       drive_r;        // bus data output enable
   logic [7:0] wdata_r;
   logic       rd_fall_s, wr_fall_s;
   logic       grant_spi_s, grant_loc_s;

   assign rd_fall_s   = ~rd_sync2_r & rd_prev_r;
   assign wr_fall_s   = ~wr_sync2_r & wr_prev_r;
   assign grant_spi_s = (state_r == ST_IDLE) & spi_pend_r;
   assign grant_loc_s = (state_r == ST_IDLE) & ~spi_pend_r & loc_req;
   assign mem_data    = drive_r ? wdata_r : 8'hzz;

   // Strobe synchronisers; resetting to 1 (inactive) means reset never looks like a fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sync1_r <= 1'b1;
         rd_sync2_r <= 1'b1;
         rd_prev_r  <= 1'b1;
         wr_sync1_r <= 1'b1;
         wr_sync2_r <= 1'b1;
         wr_prev_r  <= 1'b1;
      end else begin
         rd_sync1_r <= spi_read_n;
         rd_sync2_r <= rd_sync1_r;
         rd_prev_r  <= rd_sync2_r;
         wr_sync1_r <= spi_write_n;
         wr_sync2_r <= wr_sync1_r;
         wr_prev_r  <= wr_sync2_r;
      end
   end

   // Single-entry SPI pending slot. A fresh edge beats the grant-clear, so an edge
   // landing on the grant cycle is kept; a read edge beats a simultaneous write edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         spi_pend_r <= 1'b0;
         spi_dir_r  <= 1'b0;
      end else if (rd_fall_s | wr_fall_s) begin
         spi_pend_r <= 1'b1;
         spi_dir_r  <= ~rd_fall_s;
      end else if (grant_spi_s) begin
         spi_pend_r <= 1'b0;
      end else begin
         spi_pend_r <= spi_pend_r;
      end
   end

   // Transaction sequencer; every bus output is registered and set for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         mem_addr  <= 7'd0;
         wdata_r   <= 8'd0;
         cur_we_r  <= 1'b0;
         cur_spi_r <= 1'b0;
         drive_r   <= 1'b0;
         mem_ce_n  <= 1'b1;
         mem_oe_n  <= 1'b1;
         mem_we_n  <= 1'b1;
         busy      <= 1'b0;
         loc_ack   <= 1'b0;
         spi_rdata <= 8'd0;
         loc_rdata <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_spi_s) begin
                  mem_addr  <= spi_addr;
                  wdata_r   <= spi_wdata;
                  cur_we_r  <= spi_dir_r;
                  cur_spi_r <= 1'b1;
                  drive_r   <= spi_dir_r;
                  mem_ce_n  <= 1'b0;
                  busy      <= 1'b1;
                  state_r   <= ST_SETUP;
               end else if (grant_loc_s) begin
                  mem_addr  <= loc_addr;
                  wdata_r   <= loc_wdata;
                  cur_we_r  <= loc_we;
                  cur_spi_r <= 1'b0;
                  drive_r   <= loc_we;
                  mem_ce_n  <= 1'b0;
                  busy      <= 1'b1;
                  state_r   <= ST_SETUP;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               cnt_r    <= 4'd0;
               mem_oe_n <= cur_we_r;
               mem_we_n <= ~cur_we_r;
               state_r  <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (cnt_r == LAST_CNT) begin
                  mem_ce_n <= 1'b1;
                  mem_oe_n <= 1'b1;
                  mem_we_n <= 1'b1;
                  loc_ack  <= ~cur_spi_r;
                  // Read data is sampled on the edge that ends the last strobe cycle.
                  if (!cur_we_r && cur_spi_r) begin
                     spi_rdata <= mem_data;
                  end else if (!cur_we_r) begin
                     loc_rdata <= mem_data;
                  end else begin
                     spi_rdata <= spi_rdata;
                  end
                  cnt_r   <= 4'd0;
                  state_r <= ST_HOLD;
               end else begin
                  cnt_r   <= cnt_r + 4'd1;
                  state_r <= ST_ACCESS;
               end
            end
            ST_HOLD: begin
               loc_ack <= 1'b0;
               drive_r <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_ce_n <= 1'b1;
               mem_oe_n <= 1'b1;
               mem_we_n <= 1'b1;
               drive_r  <= 1'b0;
               busy     <= 1'b0;
               loc_ack  <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level reference model
// (phase number within a transaction, sampled strobe history, memory array)
// is compared against the DUT every cycle, with directed scenarios pinning
// hand-computed latencies and strobe widths, followed by randomized traffic.
module tb_mem_bus_arbiter;

   localparam int W = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init_phase = 1'b1;
   logic [6:0] spi_addr = 7'd0;
   logic [7:0] spi_wdata = 8'd0;
   logic       spi_read_n = 1'b1;
   logic       spi_write_n = 1'b1;
   logic       loc_req = 1'b0;
   logic       loc_we = 1'b0;
   logic [6:0] loc_addr = 7'd0;
   logic [7:0] loc_wdata = 8'd0;
   logic [7:0] spi_rdata, loc_rdata;
   logic       loc_ack, mem_ce_n, mem_oe_n, mem_we_n, busy;
   logic [6:0] mem_addr;
   wire  [7:0] mem_data;

   // instances with the extreme wait settings, each on its own private bus
   logic [7:0] spi_rdata_1, loc_rdata_1, spi_rdata_15, loc_rdata_15;
   logic       loc_ack_1, ce_n_1, oe_n_1, we_n_1, busy_1;
   logic       loc_ack_15, ce_n_15, oe_n_15, we_n_15, busy_15;
   logic [6:0] mem_addr_1, mem_addr_15;
   wire  [7:0] bus_1, bus_15;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .clk(clk), .reset(reset), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata),
      .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_rdata(loc_rdata), .loc_ack(loc_ack), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .busy(busy));

   mem_bus_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .reset(reset), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata_1),
      .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_rdata(loc_rdata_1), .loc_ack(loc_ack_1), .mem_addr(mem_addr_1), .mem_data(bus_1),
      .mem_ce_n(ce_n_1), .mem_oe_n(oe_n_1), .mem_we_n(we_n_1), .busy(busy_1));

   mem_bus_arbiter #(.WAIT_CYCLES(15)) u_dut_w15 (
      .clk(clk), .reset(reset), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata_15),
      .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
      .loc_rdata(loc_rdata_15), .loc_ack(loc_ack_15), .mem_addr(mem_addr_15), .mem_data(bus_15),
      .mem_ce_n(ce_n_15), .mem_oe_n(oe_n_15), .mem_we_n(we_n_15), .busy(busy_15));

   function automatic logic [7:0] init_val(input int i);
      if (i == 8'h7F) return 8'h3C;
      else if (i == 8'h33) return 8'h5A;
      else return 8'(i * 37 + 11);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- bus device: SRAM that answers on the main bus ----------------
   logic [7:0] dev_mem [0:127];
   assign mem_data = !mem_oe_n ? dev_mem[mem_addr] : 8'hzz;

   initial begin
      forever begin
         @(posedge clk);
         if (init_phase) begin
            for (int i = 0; i < 128; i++) dev_mem[i] = init_val(i);
         end else if (!mem_we_n) begin
            dev_mem[mem_addr] = mem_data;
         end
      end
   end

   // ---------------- reference model ----------------
   // m_t is the cycle position inside a transaction: 0 idle, 1 setup,
   // 2..W+1 strobe cycles, W+2 hold.
   int         m_t = 0;
   bit         m_spi = 1'b0, m_we = 1'b0, m_pend = 1'b0, m_dir = 1'b0;
   bit         model_valid = 1'b0, m_rf, m_wf;
   logic [6:0] m_addr = 7'd0;
   logic [7:0] m_wdata = 8'd0, m_spi_rd = 8'd0, m_loc_rd = 8'd0;
   bit   [2:0] rd_h = 3'b111, wr_h = 3'b111;   // [k] = strobe sampled k+1 edges ago
   logic [7:0] model_mem [0:127];

   initial begin
      forever begin
         @(posedge clk);
         if (init_phase) begin
            for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
         end
         if (reset) begin
            m_t = 0; m_pend = 1'b0; m_dir = 1'b0; m_addr = 7'd0;
            m_spi_rd = 8'd0; m_loc_rd = 8'd0;
            rd_h = 3'b111; wr_h = 3'b111;
            model_valid = 1'b1;
         end else begin
            // a strobe is seen falling two samples after it was sampled low
            m_rf = (rd_h[1] == 1'b0) && (rd_h[2] == 1'b1);
            m_wf = (wr_h[1] == 1'b0) && (wr_h[2] == 1'b1);
            if (m_t == 0) begin
               if (m_pend) begin
                  m_addr = spi_addr; m_wdata = spi_wdata; m_we = m_dir; m_spi = 1'b1;
                  m_pend = 1'b0; m_t = 1;
               end else if (loc_req) begin
                  m_addr = loc_addr; m_wdata = loc_wdata; m_we = loc_we; m_spi = 1'b0;
                  m_t = 1;
               end
            end else if (m_t == W + 2) begin
               m_t = 0;
            end else begin
               if (m_t == W + 1) begin
                  if (m_we) model_mem[m_addr] = m_wdata;
                  else if (m_spi) m_spi_rd = model_mem[m_addr];
                  else m_loc_rd = model_mem[m_addr];
               end
               m_t++;
            end
            if (m_rf || m_wf) begin
               m_pend = 1'b1;
               m_dir  = !m_rf;
            end
            rd_h = {rd_h[1:0], spi_read_n};
            wr_h = {wr_h[1:0], spi_write_n};
         end
      end
   end

   // ---------------- per-cycle comparison against the model ----------------
   initial begin
      logic [27:0] act_v, exp_v;
      bit e_ce, e_oe, e_we, e_busy, e_ack;
      forever begin
         @(negedge clk);
         if (model_valid) begin
            e_ce   = !(m_t >= 1 && m_t <= W + 1);
            e_oe   = !(!m_we && m_t >= 2 && m_t <= W + 1);
            e_we   = !(m_we && m_t >= 2 && m_t <= W + 1);
            e_busy = (m_t != 0);
            e_ack  = (!m_spi && m_t == W + 2);
            act_v = {mem_addr, mem_ce_n, mem_oe_n, mem_we_n, busy, loc_ack, spi_rdata, loc_rdata};
            exp_v = {m_addr, e_ce, e_oe, e_we, e_busy, e_ack, m_spi_rd, m_loc_rd};
            check("cycle_outputs", int'(act_v), int'(exp_v));
            if (m_t >= 1 && m_we) check("write_data", int'(mem_data), int'(m_wdata));
         end
      end
   end

   // ---------------- stimulus and directed checks ----------------
   initial begin
      int ack_at, rd_at, cnt_we, cnt_ce, cnt_oe, cnt_d, busy_cnt;
      int oe0, we0, ce0, oe1, we1, ce1, oe15, we15, ce15;
      logic [6:0] first_addr;

      repeat (3) @(negedge clk);
      check("reset_strobes", int'({mem_ce_n, mem_oe_n, mem_we_n}), 7);
      check("reset_busy_ack", int'({busy, loc_ack}), 0);
      check("reset_rdata", int'({spi_rdata, loc_rdata}), 0);
      reset = 1'b0; init_phase = 1'b0;
      @(negedge clk);

      // local write 0x15 <- 0xA5
      loc_we = 1'b1; loc_addr = 7'h15; loc_wdata = 8'hA5; loc_req = 1'b1;
      ack_at = 0; cnt_we = 0; cnt_ce = 0; cnt_d = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!mem_we_n) cnt_we++;
         if (!mem_ce_n) cnt_ce++;
         if (mem_data === 8'hA5) cnt_d++;
         if (loc_ack) begin ack_at = k; loc_req = 1'b0; break; end
      end
      check("lw_ack_cycle", ack_at, 4);
      check("lw_we_width", cnt_we, 2);
      check("lw_ce_width", cnt_ce, 3);
      check("lw_data_cycles", cnt_d, 4);

      // local read back 0x15
      @(negedge clk);
      loc_we = 1'b0; loc_req = 1'b1;
      ack_at = 0; cnt_oe = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!mem_oe_n) cnt_oe++;
         if (loc_ack) begin
            ack_at = k; loc_req = 1'b0;
            check("lr_rdata", int'(loc_rdata), 8'hA5);
            break;
         end
      end
      check("lr_ack_cycle", ack_at, 4);
      check("lr_oe_width", cnt_oe, 2);

      // SPI read of 0x7F
      @(negedge clk);
      spi_addr = 7'h7F;
      @(negedge clk);
      #2 spi_read_n = 1'b0;
      rd_at = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (rd_at == 0 && spi_rdata == 8'h3C) rd_at = k;
      end
      spi_read_n = 1'b1;
      check("spi_rd_within_7", int'(rd_at >= 1 && rd_at <= 7), 1);

      // contention: SPI write edge and local read decided in the same IDLE cycle
      @(negedge clk);
      spi_addr = 7'h01; spi_wdata = 8'h11; loc_we = 1'b0; loc_addr = 7'h02;
      #2 spi_write_n = 1'b0;
      repeat (3) @(negedge clk);
      loc_req = 1'b1;
      ack_at = 0; first_addr = 7'h7F;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) first_addr = mem_addr;
         if (loc_ack) begin ack_at = k; loc_req = 1'b0; break; end
      end
      spi_write_n = 1'b1;
      check("cont_spi_first", int'(first_addr), 7'h01);
      check("cont_ack_cycle", ack_at, 9);

      // SPI read arrives while a local read is in its strobe phase
      @(negedge clk);
      loc_we = 1'b0; loc_addr = 7'h10; loc_req = 1'b1; spi_addr = 7'h33;
      repeat (2) @(negedge clk);
      #2 spi_read_n = 1'b0;
      ack_at = 0; rd_at = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (loc_ack) begin ack_at = k; loc_req = 1'b0; end
         if (rd_at == 0 && spi_rdata == 8'h5A) rd_at = k;
      end
      spi_read_n = 1'b1;
      check("mid_local_ack", ack_at, 2);
      check("mid_spi_within_11", int'(rd_at > ack_at && rd_at <= 11), 1);

      // reset during a write strobe
      @(negedge clk);
      loc_we = 1'b1; loc_addr = 7'h44; loc_wdata = model_mem[7'h44]; loc_req = 1'b1;
      cnt_we = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (!mem_we_n) begin cnt_we = 1; break; end
      end
      check("rst_saw_write_strobe", cnt_we, 1);
      reset = 1'b1; loc_req = 1'b0;
      @(negedge clk);
      check("rst_mid_strobes", int'({mem_ce_n, mem_oe_n, mem_we_n}), 7);
      check("rst_mid_busy_ack", int'({busy, loc_ack}), 0);
      check("rst_mid_rdata", int'({spi_rdata, loc_rdata}), 0);
      check("rst_mid_addr", int'(mem_addr), 0);
      reset = 1'b0;
      busy_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("rst_no_false_edge", busy_cnt, 0);

      // both SPI strobes fall together: one read, no write, on every wait setting
      spi_addr = 7'h22;
      #2 begin spi_read_n = 1'b0; spi_write_n = 1'b0; end
      oe0 = 0; we0 = 0; ce0 = 0; oe1 = 0; we1 = 0; ce1 = 0; oe15 = 0; we15 = 0; ce15 = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (!mem_oe_n) oe0++;
         if (!mem_we_n) we0++;
         if (!mem_ce_n) ce0++;
         if (!oe_n_1) oe1++;
         if (!we_n_1) we1++;
         if (!ce_n_1) ce1++;
         if (!oe_n_15) oe15++;
         if (!we_n_15) we15++;
         if (!ce_n_15) ce15++;
      end
      spi_read_n = 1'b1; spi_write_n = 1'b1;
      check("both_w2_oe", oe0, 2);
      check("both_w2_we", we0, 0);
      check("both_w2_ce", ce0, 3);
      check("both_w1_oe", oe1, 1);
      check("both_w1_we", we1, 0);
      check("both_w1_ce", ce1, 2);
      check("both_w15_oe", oe15, 15);
      check("both_w15_we", we15, 0);
      check("both_w15_ce", ce15, 16);

      // randomized traffic on both ports
      fork
         begin
            int sel;
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(5, 30)) @(negedge clk);
               spi_addr = 7'($urandom); spi_wdata = 8'($urandom);
               sel = $urandom_range(0, 9);
               #($urandom_range(1, 3));
               if (sel == 0) begin spi_read_n = 1'b0; spi_write_n = 1'b0; end
               else if (sel < 5) spi_read_n = 1'b0;
               else spi_write_n = 1'b0;
               repeat ($urandom_range(2 * W + 7, 2 * W + 12)) @(negedge clk);
               #($urandom_range(1, 3));
               spi_read_n = 1'b1; spi_write_n = 1'b1;
            end
         end
         begin
            for (int n = 0; n < 1800; n++) begin
               @(negedge clk);
               if (loc_ack) begin
                  loc_req = 1'($urandom_range(0, 1));
                  loc_we = 1'($urandom); loc_addr = 7'($urandom); loc_wdata = 8'($urandom);
               end else if (!loc_req && $urandom_range(0, 3) == 0) begin
                  loc_we = 1'($urandom); loc_addr = 7'($urandom); loc_wdata = 8'($urandom);
                  loc_req = 1'b1;
               end
            end
            // let an outstanding local request complete before dropping it
            for (int n = 0; n < 40 && loc_req; n++) begin
               @(negedge clk);
               if (loc_ack) loc_req = 1'b0;
            end
            check("rand_local_drained", int'(loc_req), 0);
            loc_req = 1'b0;
         end
      join

      repeat (60) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
